// File: rtl/macro_mux_ndff_pkg.sv
// Shared types and default constants for the mux-ndff CDC launcher.
// Optional timeout support is enabled by defining MUXNDFF_TX_TIMEOUT_EN.
package macro_mux_ndff_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_e;

   localparam int DEF_WIDTH          = 8;
   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/macro_ndff_sr.sv
// STAGES-deep flop chain bringing an asynchronous level into the clk domain.
module macro_ndff_sr #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/macro_mux_ndff_tx.sv
// Source-side launcher for the mux-ndff CDC path: 4-phase en/ack handshake with a held word.
// Define MUXNDFF_TX_TIMEOUT_EN to add the REQ/DROP wait limit and the err_timeout flag.
module macro_mux_ndff_tx
   import macro_mux_ndff_pkg::*;
#(
   parameter int MUXNDFF_WIDTH  = DEF_WIDTH,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES
`ifdef MUXNDFF_TX_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [MUXNDFF_WIDTH-1:0] in_data,
   output logic                     in_ready,
   input  logic                     ack_async,
   output logic                     en,
   output logic [MUXNDFF_WIDTH-1:0] data_hold,
   output logic                     done,
   output logic                     busy,
   output state_e                   dbg_state
`ifdef MUXNDFF_TX_TIMEOUT_EN
   ,
   output logic                     err_timeout
`endif
);

   // Handshake: a word moves when in_valid && in_ready at a clk edge; in_ready is high only
   // in IDLE, so upstream holds in_valid/in_data until that edge. Downstream sees en rise with
   // data_hold already stable, and en falls only after ack_sync rises.
   logic                     ack_sync;
   state_e                   state_q, state_d;
   logic                     en_q, en_d;
   logic [MUXNDFF_WIDTH-1:0] hold_q, hold_d;
   logic                     done_q, done_d;

   macro_ndff_sr #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack_async),
      .q   (ack_sync)
   );

`ifdef MUXNDFF_TX_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             expired;
`endif

   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
`ifdef MUXNDFF_TX_TIMEOUT_EN
      err_d   = err_q;
      cnt_d   = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
      expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               hold_d  = in_data;
               en_d    = 1'b1;
               state_d = REQ;
`ifdef MUXNDFF_TX_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         REQ: begin
            if (ack_sync) begin
               en_d    = 1'b0;
               state_d = DROP;
`ifdef MUXNDFF_TX_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
`ifdef MUXNDFF_TX_TIMEOUT_EN
            else if (expired) begin
               en_d    = 1'b0;
               state_d = DROP;
               err_d   = 1'b1;
               cnt_d   = '0;
            end
`endif
         end
         DROP: begin
            if (!ack_sync) begin
               state_d = IDLE;
`ifdef MUXNDFF_TX_TIMEOUT_EN
               // A transfer that already timed out in REQ finishes silently.
               done_d  = !err_q;
`else
               done_d  = 1'b1;
`endif
            end
`ifdef MUXNDFF_TX_TIMEOUT_EN
            else if (expired) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            en_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         en_q    <= 1'b0;
         hold_q  <= '0;
         done_q  <= 1'b0;
`ifdef MUXNDFF_TX_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
`ifdef MUXNDFF_TX_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign en        = en_q;
   assign data_hold = hold_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == IDLE);
   assign dbg_state = state_q;
`ifdef MUXNDFF_TX_TIMEOUT_EN
   assign err_timeout = err_q;
`endif

endmodule

// File: tb/tb_macro_mux_ndff_tx.sv
// Directed bench for macro_mux_ndff_tx with a 3-cycle destination ack model.
// Define MUXNDFF_TX_TIMEOUT_EN to include the stuck-ack timeout sequence.
module tb_macro_mux_ndff_tx;
   import macro_mux_ndff_pkg::*;

   localparam int W = 8;
   // Each phase: 1 cycle en register + 3 destination + 2 synchronizer flops.
   localparam int EXP_LAT = 12;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         ack_async;
   logic         en;
   logic [W-1:0] data_hold;
   logic         done;
   logic         busy;
   state_e       dbg_state;
`ifdef MUXNDFF_TX_TIMEOUT_EN
   logic         err_timeout;
`endif

   always #5 clk = ~clk;

   macro_mux_ndff_tx #(
      .MUXNDFF_WIDTH  (W),
      .SYNC_STAGES    (2)
`ifdef MUXNDFF_TX_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .ack_async   (ack_async),
      .en          (en),
      .data_hold   (data_hold),
      .done        (done),
      .busy        (busy),
      .dbg_state   (dbg_state)
`ifdef MUXNDFF_TX_TIMEOUT_EN
      ,
      .err_timeout (err_timeout)
`endif
   );

   // Destination model: ack follows en three cycles later.
   logic [2:0] dpipe;
   logic       ack_block;
   logic       ack_glitch;
   always @(posedge clk) begin
      if (rst) dpipe <= '0;
      else     dpipe <= {dpipe[1:0], en};
   end
   assign ack_async = (dpipe[2] & ~ack_block) | ack_glitch;

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           done_cnt = 0;
   int           last_acc = 0;
   int           last_done = 0;
   int           last_lat = 0;
   bit           prev_busy = 1'b0;
   logic [W-1:0] prev_hold = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      if (rst !== 1'b1) begin
         if (done === 1'b1) begin
            done_cnt++;
            last_done = cyc;
            last_lat  = cyc - last_acc;
            check("done_has_pending_word", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("done_word", data_hold, exp_q.pop_front());
         end
         if (prev_busy && busy === 1'b1) check("hold_stable", data_hold, prev_hold);
         check("ready_vs_busy", in_ready, !busy);
         if (busy === 1'b1) check("en_only_in_req", en, dbg_state == REQ);
      end
      prev_busy = (busy === 1'b1);
      prev_hold = data_hold;
   endtask

   // One clock: record accept/reset at the edge, then check at the falling edge.
   task automatic tick();
      logic acc;
      logic r;
      acc = in_valid && in_ready && !rst;
      r   = rst;
      @(posedge clk);
      cyc++;
      if (r === 1'b1) exp_q.delete();
      else if (acc === 1'b1) begin
         exp_q.push_back(in_data);
         last_acc = cyc;
      end
      @(negedge clk);
      monitor();
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_word(input logic [W-1:0] w);
      bit   ok;
      logic r;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      for (int i = 0; i < 60 && !ok; i++) begin
         r = in_ready;
         tick();
         if (r === 1'b1) ok = 1'b1;
      end
      in_valid = 1'b0;
      check("accepted", 32'(ok), 1);
   endtask

   task automatic wait_done(input int max_cyc);
      int start;
      start = done_cnt;
      for (int i = 0; i < max_cyc && done_cnt == start; i++) tick();
      check("done_within_bound", done_cnt - start, 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [W-1:0] din;
      int           gap;
      logic [W-1:0] exp_hold;
      int           exp_lat;
   } vec_t;
   vec_t vecs[6];

   logic [W-1:0] b2b_w[3];

   initial begin
      int   idx;
      int   first;
      int   start;
      logic r;

      vecs[0] = '{8'hA5, 0, 8'hA5, EXP_LAT};
      vecs[1] = '{8'h00, 3, 8'h00, EXP_LAT};
      vecs[2] = '{8'hFF, 1, 8'hFF, EXP_LAT};
      vecs[3] = '{8'h5A, 0, 8'h5A, EXP_LAT};
      vecs[4] = '{8'h80, 2, 8'h80, EXP_LAT};
      vecs[5] = '{8'h01, 0, 8'h01, EXP_LAT};
      b2b_w   = '{8'h11, 8'h22, 8'h33};

      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      ack_block  = 1'b0;
      ack_glitch = 1'b0;
      @(negedge clk);
      tick();
      tick();
      check("rst_en", en, 0);
      check("rst_data_hold", data_hold, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, IDLE);
      check("rst_in_ready", in_ready, 1);
`ifdef MUXNDFF_TX_TIMEOUT_EN
      check("rst_err_timeout", err_timeout, 0);
`endif
      rst = 1'b0;
      tick();

      // Single transfers from the table.
      foreach (vecs[k]) begin
         for (int g = 0; g < vecs[k].gap; g++) tick();
         drive_word(vecs[k].din);
         check("vec_en_after_accept", en, 1);
         check("vec_data_hold", data_hold, vecs[k].exp_hold);
         check("vec_in_ready_low", in_ready, 0);
         check("vec_state_req", dbg_state, REQ);
         wait_done(40);
         check("vec_latency", last_lat, vecs[k].exp_lat);
         tick();
         check("vec_done_one_cycle", done, 0);
         check("vec_back_idle", dbg_state, IDLE);
      end

      // Back-to-back with in_valid held: accept lands on each done cycle.
      start    = done_cnt;
      first    = 0;
      idx      = 0;
      in_valid = 1'b1;
      in_data  = b2b_w[0];
      for (int i = 0; i < 200 && idx < 3; i++) begin
         r = in_ready;
         tick();
         if (r === 1'b1) begin
            if (idx == 0) first = cyc;
            idx++;
            if (idx < 3) in_data = b2b_w[idx];
         end
      end
      in_valid = 1'b0;
      check("b2b_accepts", idx, 3);
      for (int i = 0; i < 60 && done_cnt < start + 3; i++) tick();
      check("b2b_done_count", done_cnt - start, 3);
      check("b2b_span", last_done - first, 3 * EXP_LAT + 2);
      tick();

      // in_valid during REQ must not be captured.
      drive_word(8'h3C);
      tick();
      in_valid = 1'b1;
      in_data  = 8'hFF;
      for (int i = 0; i < 3; i++) tick();
      in_valid = 1'b0;
      check("mid_ignore_hold", data_hold, 8'h3C);
      check("mid_still_busy", busy, 1);
      wait_done(40);
      tick();
      check("mid_no_extra_word", exp_q.size(), 0);

      // Reset while in REQ aborts without done.
      drive_word(8'hC3);
      tick();
      check("rstreq_in_req", dbg_state, REQ);
      start = done_cnt;
      rst   = 1'b1;
      tick();
      rst   = 1'b0;
      check("rstreq_en", en, 0);
      check("rstreq_data_hold", data_hold, 0);
      check("rstreq_state", dbg_state, IDLE);
      check("rstreq_done", done, 0);
      for (int i = 0; i < 20; i++) tick();
      check("rstreq_no_done", done_cnt - start, 0);

      // Ack glitch while idle: ignored.
      start      = done_cnt;
      ack_glitch = 1'b1;
      tick();
      ack_glitch = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("glitch_state_idle", dbg_state, IDLE);
         check("glitch_en_low", en, 0);
      end
      check("glitch_no_done", done_cnt - start, 0);
      drive_word(8'h96);
      wait_done(40);
      check("post_glitch_latency", last_lat, EXP_LAT);
      tick();

`ifdef MUXNDFF_TX_TIMEOUT_EN
      // Ack stuck low: en drops after 16 REQ cycles, flag set, no done.
      start     = done_cnt;
      ack_block = 1'b1;
      drive_word(8'h77);
      idx = 0;
      for (int i = 0; i < 60 && en === 1'b1; i++) begin
         idx++;
         tick();
      end
      check("to_en_cycles", idx, 16);
      check("to_err_set", err_timeout, 1);
      for (int i = 0; i < 5; i++) tick();
      check("to_state_idle", dbg_state, IDLE);
      check("to_no_done", done_cnt - start, 0);
      exp_q.delete();
      ack_block = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      drive_word(8'h78);
      check("to_err_cleared", err_timeout, 0);
      wait_done(40);
      check("to_recover_latency", last_lat, EXP_LAT);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
